// File: rtl/spi_slave_responder.sv
// spi_slave_responder: oversampled SPI slave (all CPOL/CPHA modes, MSB-first DW-bit frames)
// with a one-deep tx holding register and a byte-level rx valid/ack handshake.
module spi_slave_responder #(
    parameter int              DW          = 8,
    parameter logic [DW-1:0]   IDLE_BYTE   = {DW{1'b1}},
    parameter int              SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpol,
    input  logic          cpha,
    input  logic [DW-1:0] tx_byte,
    input  logic          tx_load,
    output logic          tx_ready,
    output logic [DW-1:0] rx_byte,
    output logic          rx_valid,
    input  logic          rx_ack,
    output logic          rx_overrun,
    input  logic          ovr_clr,
    output logic          slave_done,
    output logic          tx_underrun,
    input  logic          spi_sclk,
    input  logic          spi_cs_n,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic          spi_miso_oe
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;
    localparam int            CW   = $clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic                   r_sclk_d, r_cs_d;
    state_t                 r_state;
    logic [CW-1:0]          r_bitcnt;
    logic [DW-1:0]          r_tx_shift, r_rx_shift, r_hold, r_rx_byte;
    logic                   r_hold_full, r_skip, r_complete, r_rx_valid;
    logic                   r_overrun, r_done, r_underrun, r_oe;
    logic                   w_sclk, w_cs_n, w_mosi, w_toggle, w_lead, w_trail;
    logic                   w_sample, w_shift, w_cs_fall, w_load, w_accept;

    assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n    = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
    assign w_toggle  = w_sclk ^ r_sclk_d;
    assign w_lead    = w_toggle & (w_sclk ^ cpol);
    assign w_trail   = w_toggle & ~(w_sclk ^ cpol);
    assign w_sample  = (r_state == S_SHIFT) & (cpha ? w_trail : w_lead);
    assign w_shift   = (r_state == S_SHIFT) & (cpha ? w_lead : w_trail);
    assign w_cs_fall = r_cs_d & ~w_cs_n;
    // Shift register (re)load: after a cs_n fall, or right after a completed frame while cs_n stays low
    assign w_load    = ~w_cs_n & ((r_state == S_LOAD) | r_complete);
    // A load that empties the holding register frees it for a tx_load in the same cycle
    assign w_accept  = tx_load & (~r_hold_full | w_load);

    assign tx_ready    = ~r_hold_full;
    assign rx_byte     = r_rx_byte;
    assign rx_valid    = r_rx_valid;
    assign rx_overrun  = r_overrun;
    assign slave_done  = r_done;
    assign tx_underrun = r_underrun;
    assign spi_miso    = r_oe & r_tx_shift[DW-1];
    assign spi_miso_oe = r_oe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
            r_state     <= S_IDLE;
            r_bitcnt    <= '0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_hold      <= '0;
            r_rx_byte   <= '0;
            r_hold_full <= 1'b0;
            r_skip      <= 1'b0;
            r_complete  <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
            r_done      <= 1'b0;
            r_underrun  <= 1'b0;
            r_oe        <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_sclk_d    <= w_sclk;
            r_cs_d      <= w_cs_n;
            r_hold_full <= w_accept | (r_hold_full & ~w_load);
            if (w_accept)
                r_hold <= tx_byte;
            r_underrun <= w_load & ~r_hold_full;
            // The first shift-type edge after a load is swallowed: in cpha=1 it only presents the
            // MSB, in cpha=0 it is the trailing edge that closes the previous back-to-back frame.
            if (w_load) begin
                r_tx_shift <= r_hold_full ? r_hold : IDLE_BYTE;
                r_skip     <= cpha | r_complete;
            end else if (w_shift) begin
                r_skip <= 1'b0;
                if (!r_skip)
                    r_tx_shift <= {r_tx_shift[DW-2:0], 1'b0};
            end
            r_complete <= w_sample & (r_bitcnt == LAST);
            r_done     <= r_complete;
            if (r_complete)
                r_rx_byte <= r_rx_shift;
            r_rx_valid <= r_complete | (r_rx_valid & ~rx_ack);
            r_overrun  <= (r_complete & r_rx_valid & ~rx_ack) | (r_overrun & ~ovr_clr);
            case (r_state)
                S_IDLE: begin
                    r_oe     <= 1'b0;
                    r_bitcnt <= '0;
                    if (w_cs_fall)
                        r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_bitcnt <= '0;
                    r_oe     <= ~w_cs_n;
                    r_state  <= w_cs_n ? S_IDLE : S_SHIFT;
                end
                default: begin
                    if (w_cs_n & ~r_complete) begin
                        r_state  <= S_IDLE;
                        r_oe     <= 1'b0;
                        r_bitcnt <= '0;
                    end else if (w_sample) begin
                        r_rx_shift <= {r_rx_shift[DW-2:0], w_mosi};
                        r_bitcnt   <= (r_bitcnt == LAST) ? '0 : r_bitcnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- Standalone SPI responder (slave) that answers an external SPI master on spi_sclk/spi_cs_n/spi_mosi/spi_miso. It supports all four CPOL/CPHA modes and MSB-first frames of DW bits.
- It oversamples the SPI pins in the system clk domain and presents a byte-level transmit/receive handshake to local logic.
- It is the receiving-end counterpart of the master inside spi_top, and is used where the far device is an off-chip or independently clocked master.

Parameters:
- DW, 8, frame width in bits (≥2).
- IDLE_BYTE, 8'hFF, value shifted out when no tx byte is loaded (underrun).
- SYNC_STAGES, 2, synchronizer flops on each SPI input (≥2).

Ports:
- clk  in  1  system clock; must run ≥8× spi_sclk.
- rst  in  1  asynchronous, active-low reset.
- cpol  in  1  sclk idle level; must be static while spi_cs_n is low.
- cpha  in  1  0 = sample on leading edge; 1 = sample on trailing edge.
- tx_byte  in  DW  next byte to transmit.
- tx_load  in  1  load strobe; accepted only when tx_ready=1.
- tx_ready  out  1  tx holding register empty.
- rx_byte  out  DW  last complete received byte.
- rx_valid  out  1  rx_byte unread; held until rx_ack.
- rx_ack  in  1  consumes rx_byte.
- rx_overrun  out  1  sticky; set when a byte completes while rx_valid=1.
- ovr_clr  in  1  clears rx_overrun.
- slave_done  out  1  one-cycle pulse per completed frame.
- tx_underrun  out  1  one-cycle pulse when IDLE_BYTE is loaded instead of user data.
- spi_sclk  in  1  SPI clock from master.
- spi_cs_n  in  1  chip select, active low.
- spi_mosi  in  1  master-out data.
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  tri-state enable; 1 = drive.

Behaviour:
- Reset (rst=0, async):
  - tx_ready=1; rx_valid=0; rx_byte=0; rx_overrun=0; slave_done=0; tx_underrun=0; spi_miso=0; spi_miso_oe=0.
  - State = IDLE; bit counter = 0; holding register empty.
- Synchronization:
  - spi_sclk, spi_cs_n and spi_mosi each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized sclk versus its registered copy.
  - Leading edge = transition away from cpol; trailing edge = transition back to cpol.
- States:
  - IDLE: cs_n_sync=1; miso_oe=0.
  - LOAD: one cycle after a cs_n_sync falling edge. The shift register loads the holding register, or IDLE_BYTE if empty, which pulses tx_underrun. If holding was full, tx_ready=1 the next cycle. bitcnt=0.
  - SHIFT: miso_oe=1; spi_miso = shift_reg MSB.
- SHIFT, cpha=0:
  - Sample mosi into rx_shift on each leading edge.
  - Shift tx on each trailing edge.
  - The first bit is valid from LOAD.
- SHIFT, cpha=1:
  - Shift tx on each leading edge, except the first leading edge of a frame, which only presents the already-loaded MSB.
  - Sample on each trailing edge.
- Frame completion:
  - The DW-th sample completes the frame. On the next clk: rx_byte ← assembled byte, rx_valid=1, slave_done=1 for 1 cycle, bitcnt=0.
  - If cs_n stays low, the shift register reloads immediately as in LOAD (back-to-back frames, no gap required).
- Completion while rx_valid=1: rx_byte is overwritten; rx_overrun←1.
- rx_ack with rx_valid=1 clears rx_valid next cycle.
- Completion in the same cycle as rx_ack: rx_valid stays 1 with the new byte; no overrun.
- ovr_clr clears rx_overrun. Simultaneous set and ovr_clr: set wins.
- tx_load with tx_ready=1 latches tx_byte; tx_ready=0 next cycle. tx_load with tx_ready=0 is ignored.
- Reload and tx_load in the same cycle: the old holding content goes to the shift register, the new byte is latched, and tx_ready stays 0.
- cs_n_sync rising mid-frame (abort):
  - Go to IDLE, clear bitcnt, discard the partial rx byte.
  - No slave_done; rx_byte and rx_valid are unchanged.
  - The holding register is unchanged; the shift-register byte is lost.
- Latency: slave_done asserts SYNC_STAGES+2 clk cycles after the final sampling sclk edge at the pins.

Test Plan:
- Mode 0, master sends 0xA5, tx_byte=0x3C preloaded -> master receives 0x3C; rx_byte=0xA5; rx_valid=1; one slave_done pulse; tx_ready=1 after LOAD.
- Loop {cpha,cpol}=0..3, 10 random byte pairs each -> every frame: master_tx==rx_byte and master_rx==tx_byte; zero overrun or underrun.
- Two back-to-back frames under one cs_n low (0x11 then 0x22), second tx_byte loaded mid-first-frame -> rx 0x11 then 0x22; miso sends both loaded bytes; two slave_done pulses.
- No tx_load before cs_n falls -> master receives 0xFF; tx_underrun pulses once.
- Second frame completes without rx_ack -> rx_byte=second byte; rx_overrun=1 until ovr_clr.
- cs_n deasserted after 3 sclk edges; separately, rst pulsed low mid-frame -> abort: no slave_done, rx_valid unchanged, next full frame correct; rst: all outputs at reset values immediately, clean frame afterwards.
